// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared types and limits for the LC3 multi-channel memory responder.
//   ch_id_t     - channel number, sized for the largest supported channel count
//   rsp_stage_t - one response pipeline stage {valid, ch_id, data}
//   next_ch     - round-robin successor of a channel number
package lc3_mem_pkg;

    localparam int unsigned MAX_CH     = 8;
    localparam int unsigned MAX_LAT    = 4;
    localparam int unsigned STAT_W     = 16;
    localparam int unsigned MAX_DATA_W = 32;

    typedef logic [$clog2(MAX_CH)-1:0] ch_id_t;

    typedef struct packed {
        logic                  valid;
        ch_id_t                ch_id;
        logic [MAX_DATA_W-1:0] data;
    } rsp_stage_t;

    function automatic ch_id_t next_ch(input ch_id_t cur, input int unsigned n);
        if (int'(cur) + 1 >= int'(n)) begin
            return '0;
        end
        return cur + ch_id_t'(1);
    endfunction

endpackage

// File: rtl/lc3_rr_arbiter.sv
// lc3_rr_arbiter: round-robin arbiter over NUM_CH requestors.
//   clock, reset (async active-low)
//   req     - per-channel request
//   accept  - the current grant is taken this cycle; advances the search pointer
//   gnt     - one-hot grant (or zero), combinational from req and the pointer
//   gnt_id  - index of the granted channel
module lc3_rr_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int unsigned NUM_CH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic              accept,
    output logic [NUM_CH-1:0] gnt,
    output ch_id_t            gnt_id
);

    // Channel the search starts from: one past the last granted channel.
    ch_id_t start;

    always_comb begin
        logic        found;
        int unsigned idx;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = int'(start) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            for (int unsigned j = 0; j < NUM_CH; j++) begin
                if (!found && j == idx && req[j]) begin
                    gnt[j] = 1'b1;
                    gnt_id = ch_id_t'(j);
                    found  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start <= '0;
        end else if (accept) begin
            start <= next_ch(gnt_id, NUM_CH);
        end
    end

endmodule

// File: rtl/lc3_mem_model.sv
// lc3_mem_model: multi-channel memory responder for the LC3 bench (fetch on ch0,
// memaccess on ch1 by default). One shared word array, round-robin arbitration,
// fixed-latency response pipeline, no response backpressure.
//   clock, reset (async active-low)
//   req_valid/req_ready/req_we  - per-channel request handshake
//   req_addr/req_wdata          - flattened per-channel address / write data
//   rsp_valid/rsp_rdata         - per-channel one-cycle response strobe and data
//   stat_grants                 - per-channel accept counters (16 bit each)
// Optional feature macro: LC3_MEM_STATS_EN enables saturating accept counters;
// without it stat_grants is tied to zero.
module lc3_mem_model
    import lc3_mem_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        req_we,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    output logic [NUM_CH-1:0]        rsp_valid,
    output logic [NUM_CH*DATA_W-1:0] rsp_rdata,
    output logic [NUM_CH*STAT_W-1:0] stat_grants
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_ch
        $error("lc3_mem_model: NUM_CH out of range");
    end
    if (RD_LAT < 1 || RD_LAT > MAX_LAT) begin : g_bad_lat
        $error("lc3_mem_model: RD_LAT out of range");
    end
    if (DATA_W > MAX_DATA_W || ADDR_W < IDX_W) begin : g_bad_w
        $error("lc3_mem_model: unsupported width combination");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic [NUM_CH-1:0] req_gated;
    logic [NUM_CH-1:0] gnt;
    ch_id_t            gnt_id;
    logic              accept;

    // No grants while reset is held.
    assign req_gated = req_valid & {NUM_CH{reset}};
    assign req_ready = gnt;
    assign accept    = |gnt;

    lc3_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clock  (clock),
        .reset  (reset),
        .req    (req_gated),
        .accept (accept),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [IDX_W-1:0]  sel_idx;

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Upper address bits are dropped, so the index wraps modulo DEPTH.
    assign sel_idx = sel_addr[IDX_W-1:0];

    always_ff @(posedge clock) begin
        if (accept && sel_we) begin
            mem[sel_idx] <= sel_wdata;
        end
    end

    // Stage entering the pipeline; the array is sampled at the accept edge,
    // so a write accepted on the previous edge is already visible.
    rsp_stage_t in_stage;
    rsp_stage_t tail;

    always_comb begin
        in_stage       = '0;
        in_stage.valid = accept;
        in_stage.ch_id = gnt_id;
        in_stage.data  = sel_we ? MAX_DATA_W'(sel_wdata) : MAX_DATA_W'(mem[sel_idx]);
    end

    // The per-channel output registers form the last stage, so only RD_LAT-1
    // intermediate stages are needed ahead of them.
    if (RD_LAT == 1) begin : g_lat1
        assign tail = in_stage;
    end else begin : g_pipe
        rsp_stage_t stage [RD_LAT-1];

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                for (int unsigned j = 0; j < RD_LAT - 1; j++) begin
                    stage[j] <= '0;
                end
            end else begin
                stage[0] <= in_stage;
                for (int unsigned j = 1; j < RD_LAT - 1; j++) begin
                    stage[j] <= stage[j-1];
                end
            end
        end

        assign tail = stage[RD_LAT-2];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (tail.valid && tail.ch_id == ch_id_t'(i)) begin
                    rsp_valid[i]                  <= 1'b1;
                    rsp_rdata[i*DATA_W +: DATA_W] <= tail.data[DATA_W-1:0];
                end
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{sel_addr, tail.data};

`ifdef LC3_MEM_STATS_EN
    logic [STAT_W-1:0] grant_cnt [NUM_CH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                grant_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (gnt[i] && grant_cnt[i] != '1) begin
                    grant_cnt[i] <= grant_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            stat_grants[i*STAT_W +: STAT_W] = grant_cnt[i];
        end
    end
`else
    assign stat_grants = '0;
`endif

endmodule
